// File: rtl/cpec_pkg.sv
// cpec_pkg: shared constants, sizing helpers and group sideband type for the CPEC group packer.
package cpec_pkg;
    localparam logic [1:0] MODE_TC = 2'd3;
    localparam int BR_MIN = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sz_w(input int j, input int n);
        return clog2(n * j + n + 1);
    endfunction

    typedef struct packed {
        logic [1:0] ecgidx;
        logic [3:0] bits_req;
        logic       skip;
        logic       slice_start;
    } side_t;
endpackage

// File: rtl/cpec_abs.sv
// cpec_abs: J-bit signed sample to J-bit magnitude; the most negative value wraps to its own pattern.
module cpec_abs #(
    parameter int J = 10
) (
    input  logic [J-1:0] s_i,
    output logic [J-1:0] mag_o
);
    assign mag_o = s_i[J-1] ? -s_i : s_i;
endmodule

// File: rtl/cpec_group_packer.sv
// cpec_group_packer: two-stage CPEC group encoder/packer with a saturating per-slice bit total.
// Define CPEC_SIGN_EN to append per-sample sign bits below the magnitudes in sign-magnitude mode.
module cpec_group_packer
    import cpec_pkg::*;
#(
    parameter int J = 10,
    parameter int N = 4,
    parameter int CNT_W = 16,
    localparam int SZ_W = sz_w(J, N),
`ifdef CPEC_SIGN_EN
    localparam int DW = N * J + N
`else
    localparam int DW = N * J
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*J-1:0]   samples,
    input  logic [1:0]       ecgidx,
    input  logic [3:0]       bits_req,
    input  logic             group_skip,
    input  logic             slice_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    cpec_data,
    output logic [SZ_W-1:0]  cpec_size,
    output logic [CNT_W-1:0] bit_total,
    output logic             total_sat
);
    localparam int AW = (CNT_W > SZ_W ? CNT_W : SZ_W) + 1;

    logic             s1_v_q, s2_v_q, start_q, sat_q, sat_d;
    logic [N*J-1:0]   smp_q, mag_q, mag_w;
    side_t            side_q;
    logic [DW-1:0]    data_q, data_d;
    logic [SZ_W-1:0]  size_q, size_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [AW-1:0]    sum;
    logic [J-1:0]     mask, field;
    logic             s2_adv, acc, legal, tc, ovf;

    for (genvar i = 0; i < N; i++) begin : g_abs
        cpec_abs #(.J(J)) u_abs (.s_i(samples[i*J +: J]), .mag_o(mag_w[i*J +: J]));
    end

    assign s2_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_adv;
    assign acc      = in_valid && in_ready;
    assign tc       = side_q.ecgidx == MODE_TC;
    assign legal    = !side_q.skip && int'(side_q.bits_req) >= BR_MIN && int'(side_q.bits_req) <= J;

    // Shift-OR pack: each field enters at the bottom, so sample 0 ends up most significant.
    always_comb begin
        mask = ~({J{1'b1}} << side_q.bits_req);
        data_d = '0;
        field = '0;
        for (int k = 0; k < N; k++) begin
            field = (tc ? smp_q[k*J +: J] : mag_q[k*J +: J]) & mask;
            data_d = (data_d << side_q.bits_req) | DW'(field);
        end
`ifdef CPEC_SIGN_EN
        for (int k = 0; k < N; k++) data_d = tc ? data_d : {data_d[DW-2:0], smp_q[k*J+J-1]};
        size_d = legal ? SZ_W'(int'(side_q.bits_req) * N + (tc ? 0 : N)) : '0;
`else
        size_d = legal ? SZ_W'(int'(side_q.bits_req) * N) : '0;
`endif
        data_d = legal ? data_d : '0;
    end

    // A slice_start group restarts the total from zero and clears the sticky flag.
    always_comb begin
        sum = (start_q ? '0 : AW'(total_q)) + AW'(size_q);
        ovf = sum > AW'({CNT_W{1'b1}});
        total_d = ovf ? '1 : CNT_W'(sum);
        sat_d = (!start_q && sat_q) || ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            smp_q   <= '0;
            mag_q   <= '0;
            side_q  <= '0;
            s2_v_q  <= 1'b0;
            data_q  <= '0;
            size_q  <= '0;
            start_q <= 1'b0;
            total_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            if (acc) begin
                smp_q  <= samples;
                mag_q  <= mag_w;
                side_q <= '{ecgidx, bits_req, group_skip, slice_start};
            end
            s1_v_q <= acc || (s1_v_q && !s2_adv);
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    data_q  <= data_d;
                    size_q  <= size_d;
                    start_q <= side_q.slice_start;
                end
            end
            if (s2_v_q && out_ready) begin
                total_q <= total_d;
                sat_q   <= sat_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign cpec_data = data_q;
    assign cpec_size = size_q;
    assign bit_total = total_q;
    assign total_sat = sat_q;
endmodule
